// File: rtl/fmlbrg_linexfer.sv
`default_nettype none
// ============================================================================
// fmlbrg_linexfer : FML bridge cache-line refill / write-back engine
// Revision: 1.0
// ============================================================================
module fmlbrg_linexfer #(
  parameter int depth     = 11,
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start_evict,
  input  logic                 start_fetch,
  input  logic [depth-3:0]     line_idx,
  input  logic [fml_depth-5:0] evict_adr,
  input  logic [fml_depth-5:0] fetch_adr,
  output logic                 busy,
  output logic                 done,
  output logic [fml_depth-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [3:0]           fml_sel,
  input  logic [31:0]          fml_di,
  output logic [31:0]          fml_do,
  output logic [depth-1:0]     mem_a,
  output logic [3:0]           mem_we,
  output logic [31:0]          mem_di,
  output logic [depth-1:0]     mem_a2,
  input  logic [31:0]          mem_do2
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EV_REQ  = 3'd1,
    S_EV_DATA = 3'd2,
    S_FE_REQ  = 3'd3,
    S_FE_DATA = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [depth-3:0]       r_line;
  logic [fml_depth-5:0]   r_evict_adr;
  logic [fml_depth-5:0]   r_fetch_adr;
  logic                   r_pend_fetch;
  logic [1:0]             r_cnt;
  logic [1:0]             w_cnt_nxt;
  logic [1:0]             w_cnt_inc;
  logic                   w_latch;

  assign w_cnt_inc = r_cnt + 2'd1;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_line       <= '0;
      r_evict_adr  <= '0;
      r_fetch_adr  <= '0;
      r_pend_fetch <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_latch) begin
        r_line       <= line_idx;
        r_evict_adr  <= evict_adr;
        r_fetch_adr  <= fetch_adr;
        r_pend_fetch <= start_fetch;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    fml_stb     = 1'b0;
    fml_we      = 1'b0;
    fml_sel     = 4'h0;
    mem_we      = 4'h0;
    mem_a2      = {r_line, r_cnt};
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_evict || start_fetch) begin
          w_latch     = 1'b1;
          w_state_nxt = start_evict ? S_EV_REQ : S_FE_REQ;
        end
      end
      S_EV_REQ: begin
        fml_stb   = 1'b1;
        fml_we    = 1'b1;
        w_cnt_nxt = 2'd0;
        if (fml_ack) w_state_nxt = S_EV_DATA;
      end
      S_EV_DATA: begin
        // Secondary port is one cycle behind, so address runs one word ahead.
        fml_sel   = 4'hF;
        mem_a2    = {r_line, w_cnt_inc};
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == 2'd3) w_state_nxt = r_pend_fetch ? S_FE_REQ : S_FIN;
      end
      S_FE_REQ: begin
        fml_stb   = 1'b1;
        w_cnt_nxt = 2'd0;
        if (fml_ack) w_state_nxt = S_FE_DATA;
      end
      S_FE_DATA: begin
        mem_we    = 4'hF;
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == 2'd3) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        busy        = 1'b0;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign fml_adr = {((r_state == S_EV_REQ) || (r_state == S_EV_DATA)) ? r_evict_adr : r_fetch_adr, 4'b0000};
  assign fml_do  = mem_do2;
  assign mem_a   = {r_line, r_cnt};
  assign mem_di  = fml_di;

endmodule
`default_nettype wire

// File: tb/tb_fmlbrg_linexfer.sv
`default_nettype none
// ============================================================================
// tb_fmlbrg_linexfer : directed + randomized bench with a line-level memory model
// Revision: 1.0
// ============================================================================
module tb_fmlbrg_linexfer;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start_evict = 1'b0;
  logic        start_fetch = 1'b0;
  logic [8:0]  line_idx = '0;
  logic [21:0] evict_adr = '0;
  logic [21:0] fetch_adr = '0;
  logic        busy;
  logic        done;
  logic [25:0] fml_adr;
  logic        fml_stb;
  logic        fml_we;
  logic        fml_ack = 1'b0;
  logic [3:0]  fml_sel;
  logic [31:0] fml_di = '0;
  logic [31:0] fml_do;
  logic [10:0] mem_a;
  logic [3:0]  mem_we;
  logic [31:0] mem_di;
  logic [10:0] mem_a2;
  logic [31:0] mem_do2;

  int total = 0;
  int bad   = 0;

  // Data memory: primary write port plus a registered-address read port.
  logic [31:0] dmem [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [10:0] a2_q;
  logic        pre_we = 1'b0;
  logic [10:0] pre_a = '0;
  logic [31:0] pre_d = '0;

  always @(posedge sys_clk) begin
    a2_q <= mem_a2;
    if (pre_we) dmem[pre_a] <= pre_d;
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) dmem[mem_a][8*i +: 8] <= mem_di[8*i +: 8];
  end
  assign mem_do2 = dmem[a2_q];

  always #5 sys_clk = ~sys_clk;

  fmlbrg_linexfer #(.depth(11), .fml_depth(26)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .start_evict(start_evict), .start_fetch(start_fetch), .line_idx(line_idx),
    .evict_adr(evict_adr), .fetch_adr(fetch_adr),
    .busy(busy), .done(done),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_ack(fml_ack),
    .fml_sel(fml_sel), .fml_di(fml_di), .fml_do(fml_do),
    .mem_a(mem_a), .mem_we(mem_we), .mem_di(mem_di),
    .mem_a2(mem_a2), .mem_do2(mem_do2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input logic [8:0] line);
    @(negedge sys_clk);
    start_evict = 0; start_fetch = 0; fml_ack = 0;
    #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_stb", fml_stb, 0);
    chk("idle_mem_we", mem_we, 0);
    chk("idle_mem_a", mem_a, {line, 2'b00});
  endtask

  // One request, cycle by cycle; expectations come from ref_mem and the
  // request arguments. rst_beat >= 0 aborts the refill at that beat.
  task automatic run_xfer(input bit ev, input bit fe, input logic [8:0] line,
                          input logic [21:0] eadr, input logic [21:0] fadr,
                          input int kev, input int kfe, input bit noise,
                          input int rst_beat, input bit dfix, input logic [31:0] dbase);
    logic [31:0] d;
    logic [10:0] wa;
    @(negedge sys_clk);
    start_evict = ev; start_fetch = fe; line_idx = line;
    evict_adr = eadr; fetch_adr = fadr; fml_ack = 0;
    @(negedge sys_clk);
    start_evict = 0; start_fetch = 0;
    line_idx = 9'($urandom); evict_adr = 22'($urandom); fetch_adr = 22'($urandom);
    #1;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    if (ev) begin
      for (int i = 1; i <= kev; i++) begin
        if (i > 1) @(negedge sys_clk);
        fml_ack = (i == kev);
        #1;
        chk("ev_stb", fml_stb, 1);
        chk("ev_we", fml_we, 1);
        chk("ev_adr", fml_adr, {eadr, 4'b0000});
        chk("ev_req_sel", fml_sel, 0);
        chk("ev_req_a2", mem_a2, {line, 2'b00});
      end
      for (int b = 0; b < 4; b++) begin
        @(negedge sys_clk);
        start_evict = 0; start_fetch = 0;
        fml_ack = noise ? 1'($urandom) : 1'b0;
        if (noise) begin
          start_fetch = 1; line_idx = 9'($urandom); fetch_adr = 22'($urandom);
        end
        #1;
        wa = {line, 2'(b)};
        chk("ev_do", fml_do, ref_mem[wa]);
        chk("ev_sel", fml_sel, 4'hF);
        chk("ev_beat_stb", fml_stb, 0);
        chk("ev_mem_we", mem_we, 0);
        chk("ev_busy", busy, 1);
      end
    end
    if (fe) begin
      for (int i = 1; i <= kfe; i++) begin
        if (i > 1 || ev) @(negedge sys_clk);
        start_evict = 0; start_fetch = 0;
        fml_ack = (i == kfe);
        #1;
        chk("fe_stb", fml_stb, 1);
        chk("fe_we", fml_we, 0);
        chk("fe_adr", fml_adr, {fadr, 4'b0000});
        chk("fe_req_mem_we", mem_we, 0);
      end
      for (int b = 0; b < 4; b++) begin
        @(negedge sys_clk);
        fml_ack = noise ? 1'($urandom) : 1'b0;
        d = dfix ? dbase + 32'(b) : $urandom;
        fml_di = d;
        if (b == rst_beat) begin
          sys_rst = 1;
          #1;
          chk("rst_stb", fml_stb, 0);
          chk("rst_mem_we", mem_we, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_mem_a", mem_a, 0);
          chk("rst_fml_adr", fml_adr, 0);
          @(negedge sys_clk);
          sys_rst = 0; fml_ack = 0;
          for (int j = 0; j < b; j++) begin
            wa = {line, 2'(j)};
            chk("rst_partial_line", dmem[wa], ref_mem[wa]);
          end
          return;
        end
        #1;
        wa = {line, 2'(b)};
        chk("fe_mem_we", mem_we, 4'hF);
        chk("fe_mem_a", mem_a, wa);
        chk("fe_mem_di", mem_di, d);
        chk("fe_beat_stb", fml_stb, 0);
        ref_mem[wa] = d;
      end
    end
    @(negedge sys_clk);
    start_evict = 0; start_fetch = 0; fml_ack = 0;
    if (noise) begin
      start_fetch = 1; line_idx = 9'($urandom); fetch_adr = 22'($urandom);
    end
    #1;
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_stb", fml_stb, 0);
    chk("fin_mem_we", mem_we, 0);
    for (int b = 0; b < 4; b++) begin
      wa = {line, 2'(b)};
      chk("line_contents", dmem[wa], ref_mem[wa]);
    end
  endtask

  initial begin
    // Preload memory while reset is held.
    for (int i = 0; i < 2048; i++) begin
      @(negedge sys_clk);
      pre_we = 1; pre_a = 11'(i);
      pre_d = (i >= 40 && i <= 43) ? 32'hB0 + 32'(i - 40) : $urandom;
      ref_mem[i] = pre_d;
    end
    @(negedge sys_clk);
    pre_we = 0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_stb", fml_stb, 0);
    chk("reset_we", fml_we, 0);
    chk("reset_sel", fml_sel, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_a", mem_a, 0);
    chk("reset_mem_a2", mem_a2, 0);
    chk("reset_fml_adr", fml_adr, 0);
    @(negedge sys_clk);
    sys_rst = 0;

    // Fetch only, ack 3 cycles after strobe.
    run_xfer(0, 1, 9'd5, 22'h0, 22'h12345, 0, 3, 0, -1, 1, 32'hA0);
    idle_check(9'd5);
    // Evict only of preloaded words 40..43.
    run_xfer(1, 0, 9'd10, 22'h00ABC, 22'h0, 3, 0, 0, -1, 0, 0);
    idle_check(9'd10);
    // Combined evict + refill.
    run_xfer(1, 1, 9'd2, 22'($urandom), 22'($urandom), 2, 2, 0, -1, 0, 0);
    idle_check(9'd2);
    // Starts and acks during the transfer and in FIN must be ignored.
    run_xfer(1, 1, 9'd77, 22'($urandom), 22'($urandom), 1, 3, 1, -1, 0, 0);
    idle_check(9'd77);
    // Reset during refill beat 1, then a clean fetch.
    run_xfer(0, 1, 9'd33, 22'h0, 22'h3FFFF, 0, 2, 0, 1, 0, 0);
    idle_check(9'd0);
    run_xfer(0, 1, 9'd34, 22'h0, 22'h00001, 0, 2, 0, -1, 0, 0);
    // Immediate ack and highest line, back to back.
    run_xfer(0, 1, 9'd511, 22'h0, 22'h3FFFFF, 0, 1, 0, -1, 1, 32'hC0);
    run_xfer(1, 0, 9'd511, 22'h2AAAA, 22'h0, 1, 0, 0, -1, 0, 0);
    idle_check(9'd511);
    // Randomized back-to-back requests.
    for (int n = 0; n < 12; n++) begin
      int kind;
      kind = int'($urandom_range(1, 3));
      run_xfer(kind[0], kind[1], 9'($urandom), 22'($urandom), 22'($urandom),
               int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
               1'($urandom), -1, 0, 0);
    end
    idle_check(dut.r_line);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
